// File: rtl/fft256_pkg.sv
// ---------------------------------------------------------------------------
// fft256_pkg -- shared constants and types for the 256-point FFT datapath.
//
// Contents:
//   NB_DEF   : default FFT output data width base. Samples are NB_DEF+4 bits.
//   LOGN_DEF : default log2 of the frame length.
//   FFT_N    : frame length, 2**LOGN_DEF.
//   HW       : width of the headroom / shift code (values 0..3).
//   state_t  : shift detector FSM states.
//   hdrm_min : minimum of two headroom codes.
// ---------------------------------------------------------------------------
package fft256_pkg;

    localparam int NB_DEF   = 12;
    localparam int LOGN_DEF = 8;
    localparam int FFT_N    = 1 << LOGN_DEF;
    localparam int HW       = 2;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_ACC  = 1'b1
    } state_t;

    function automatic logic [HW-1:0] hdrm_min(input logic [HW-1:0] a,
                                               input logic [HW-1:0] b);
        return (a < b) ? a : b;
    endfunction

endpackage

// File: rtl/shift_det_hdrm.sv
// ---------------------------------------------------------------------------
// shift_det_hdrm -- combinational headroom of one complex sample.
//
// The headroom of a value is the number of bits directly below its sign bit
// that still equal the sign bit, looking at most three bits down. The sample
// headroom is the smaller of the real and imaginary headrooms.
//
// Ports:
//   dr   in  nb+4  real part, two's complement
//   di   in  nb+4  imaginary part, two's complement
//   hdrm out HW    sample headroom, 0..3
// ---------------------------------------------------------------------------
module shift_det_hdrm
    import fft256_pkg::*;
#(
    parameter int nb = NB_DEF
) (
    input  logic [nb+3:0] dr,
    input  logic [nb+3:0] di,
    output logic [HW-1:0] hdrm
);

    // Only the sign bit and the three bits below it matter; the count stops
    // at the first bit that differs from the sign.
    function automatic logic [HW-1:0] head(input logic [nb+3:0] x);
        if (x[nb+2] != x[nb+3])      return 2'd0;
        else if (x[nb+1] != x[nb+3]) return 2'd1;
        else if (x[nb] != x[nb+3])   return 2'd2;
        else                         return 2'd3;
    endfunction

    assign hdrm = hdrm_min(head(dr), head(di));

endmodule

// File: rtl/shift_det.sv
// ---------------------------------------------------------------------------
// shift_det -- block-floating-point shift detector for one FFT frame.
//
// Tracks the minimum sample headroom over a frame of 2**LOGN samples and,
// one edge after the last sample, publishes it as the normalizer left-shift
// code together with a one-cycle (ED-qualified) RDY strobe. START restarts
// a frame at any time, discarding a partial one. All state holds while ED=0.
//
// Ports:
//   CLK   in  1     clock, rising edge
//   RST   in  1     asynchronous, active-high reset
//   ED    in  1     enable; state and outputs hold when low
//   START in  1     sample 0 of a frame (sampled with ED=1)
//   DR    in  nb+4  real part of current sample
//   DI    in  nb+4  imaginary part of current sample
//   SHIFT out 2     shift code, valid from RDY until the next RDY
//   RDY   out 1     frame-result strobe
//   BUSY  out 1     high while a frame is being accumulated
//
// Build option:
//   SHIFT_DET_MARGIN_EN : when defined, SHIFT = max(min_headroom-1, 0),
//                         keeping one guard bit for normalizer rounding.
//                         Otherwise SHIFT = min_headroom.
// ---------------------------------------------------------------------------
module shift_det
    import fft256_pkg::*;
#(
    parameter int nb   = NB_DEF,
    parameter int LOGN = LOGN_DEF
) (
    input  logic          CLK,
    input  logic          RST,
    input  logic          ED,
    input  logic          START,
    input  logic [nb+3:0] DR,
    input  logic [nb+3:0] DI,
    output logic [HW-1:0] SHIFT,
    output logic          RDY,
    output logic          BUSY
);

    state_t          state_r, state_nxt;
    logic [LOGN-1:0] cnt_r, cnt_nxt;
    logic [HW-1:0]   min_r, min_nxt;
    logic [HW-1:0]   shift_nxt;
    logic            rdy_nxt;
    logic [HW-1:0]   hdrm;
    logic [HW-1:0]   min_acc;

    shift_det_hdrm #(
        .nb   (nb)
    ) u_hdrm (
        .dr   (DR),
        .di   (DI),
        .hdrm (hdrm)
    );

    function automatic logic [HW-1:0] to_shift(input logic [HW-1:0] m);
`ifdef SHIFT_DET_MARGIN_EN
        return (m == '0) ? '0 : m - 1'b1;
`else
        return m;
`endif
    endfunction

    // Running minimum including the current sample.
    assign min_acc = hdrm_min(min_r, hdrm);

    always_comb begin
        // NOTE: every output of this block gets a default first so no path
        // leaves a signal unassigned, which would infer a latch.
        state_nxt = state_r;
        cnt_nxt   = cnt_r;
        min_nxt   = min_r;
        shift_nxt = SHIFT;
        rdy_nxt   = 1'b0;   // strobe: cleared on every enabled edge

        if (START) begin
            // Restart wins over everything, including the last-sample case.
            state_nxt = S_ACC;
            cnt_nxt   = LOGN'(1);
            min_nxt   = hdrm;
        end else if (state_r == S_ACC) begin
            cnt_nxt = cnt_r + LOGN'(1);   // wraps to 0 after the last sample
            min_nxt = min_acc;
            if (cnt_r == '1) begin
                shift_nxt = to_shift(min_acc);
                rdy_nxt   = 1'b1;
                state_nxt = S_IDLE;
            end
        end
    end

    // NOTE: state registers use non-blocking assignments so all of them
    // update together from values computed before the edge.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_r <= S_IDLE;
            cnt_r   <= '0;
            min_r   <= 2'd3;
            SHIFT   <= '0;
            RDY     <= 1'b0;
        end else if (ED) begin
            state_r <= state_nxt;
            cnt_r   <= cnt_nxt;
            min_r   <= min_nxt;
            SHIFT   <= shift_nxt;
            RDY     <= rdy_nxt;
        end
    end

    assign BUSY = (state_r == S_ACC);

endmodule
